// File: rtl/craps_pkg.sv
// Shared types and constants for the craps game controller.
// Purely declarative: no latency, no flow control.
package craps_pkg;

    typedef enum logic [2:0] {
        S_COMEOUT,
        S_POINT,
        S_WAIT,
        S_EVAL,
        S_WIN,
        S_LOSE
    } state_t;

    localparam int SUM_W = 4;
    localparam int DIE_W = 3;
    localparam int CNT_W = 8;
    localparam int LAT_W = 3;

    localparam logic [DIE_W-1:0] DIE_MIN = 3'd1;
    localparam logic [DIE_W-1:0] DIE_MAX = 3'd6;

    localparam logic [SUM_W-1:0] NATURAL_7  = 4'd7;
    localparam logic [SUM_W-1:0] NATURAL_11 = 4'd11;
    localparam logic [SUM_W-1:0] CRAPS_2    = 4'd2;
    localparam logic [SUM_W-1:0] CRAPS_3    = 4'd3;
    localparam logic [SUM_W-1:0] CRAPS_12   = 4'd12;

    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    function automatic logic die_ok(input logic [DIE_W-1:0] d);
        return (d >= DIE_MIN) && (d <= DIE_MAX);
    endfunction

endpackage

// File: rtl/craps_judge.sv
// Combinational rule table: sums two faces and classifies the roll.
// Zero latency; no flow control, evaluated whenever the controller samples it.
module craps_judge
    import craps_pkg::*;
(
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    input  logic [SUM_W-1:0] point,
    input  logic             comeout,
    output logic [SUM_W-1:0] sum,
    output logic             illegal,
    output logic             is_win,
    output logic             is_lose,
    output logic             set_point
);

    always_comb begin
        sum       = {1'b0, die_a} + {1'b0, die_b};
        illegal   = !die_ok(die_a) || !die_ok(die_b);
        is_win    = 1'b0;
        is_lose   = 1'b0;
        set_point = 1'b0;
        if (!illegal) begin
            if (comeout) begin
                if (sum == NATURAL_7 || sum == NATURAL_11) begin
                    is_win = 1'b1;
                end else if (sum == CRAPS_2 || sum == CRAPS_3 || sum == CRAPS_12) begin
                    is_lose = 1'b1;
                end else begin
                    set_point = 1'b1;
                end
            end else begin
                // Point match is tested before 7: a point can never be 7 anyway.
                if (sum == point) begin
                    is_win = 1'b1;
                end else if (sum == NATURAL_7) begin
                    is_lose = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/craps_ctrl.sv
// Craps game controller: button edge -> roll strobe -> wait DIE_LAT -> judge dice.
// Result visible DIE_LAT+2 cycles after the press; presses during WAIT/EVAL are dropped.
// Optional win/loss statistics counters are built when CRAPS_STATS_EN is defined.
module craps_ctrl
    import craps_pkg::*;
#(
    parameter int DIE_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn,
    input  logic [DIE_W-1:0] die_a,
    input  logic [DIE_W-1:0] die_b,
    output logic             roll_req,
    output logic [SUM_W-1:0] sum,
    output logic [SUM_W-1:0] point,
    output logic             win,
    output logic             lose,
    output logic             die_err,
    output logic [CNT_W-1:0] roll_cnt,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses
);

    // WAIT lasts DIE_LAT cycles, so the counter starts one below the latency.
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DIE_LAT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_btn_q;
    logic             r_ret_comeout;
    logic             r_roll_req;
    logic             r_die_err;
    logic [LAT_W-1:0] r_lat_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] r_point;
    logic [CNT_W-1:0] r_roll_cnt;

    logic             w_press;
    logic             w_roll_start;
    logic             w_new_game;
    logic             w_eval_ok;
    logic [SUM_W-1:0] w_sum;
    logic             w_illegal;
    logic             w_is_win;
    logic             w_is_lose;
    logic             w_set_point;

    assign w_press   = btn & ~r_btn_q;
    assign w_eval_ok = (r_state == S_EVAL) && !w_illegal;

    craps_judge u_judge (
        .die_a     (die_a),
        .die_b     (die_b),
        .point     (r_point),
        .comeout   (r_ret_comeout),
        .sum       (w_sum),
        .illegal   (w_illegal),
        .is_win    (w_is_win),
        .is_lose   (w_is_lose),
        .set_point (w_set_point)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_COMEOUT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_roll_start = 1'b0;
        w_new_game   = 1'b0;
        case (r_state)
            S_COMEOUT, S_POINT: begin
                if (w_press) begin
                    w_state_nxt  = S_WAIT;
                    w_roll_start = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (w_illegal) begin
                    w_state_nxt = r_ret_comeout ? S_COMEOUT : S_POINT;
                end else if (w_is_win) begin
                    w_state_nxt = S_WIN;
                end else if (w_is_lose) begin
                    w_state_nxt = S_LOSE;
                end else begin
                    w_state_nxt = S_POINT;
                end
            end
            S_WIN, S_LOSE: begin
                if (w_press) begin
                    w_state_nxt = S_COMEOUT;
                    w_new_game  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_COMEOUT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q       <= 1'b0;
            r_ret_comeout <= 1'b1;
            r_roll_req    <= 1'b0;
            r_die_err     <= 1'b0;
            r_lat_cnt     <= '0;
            r_sum         <= '0;
            r_point       <= '0;
            r_roll_cnt    <= '0;
        end else begin
            r_btn_q    <= btn;
            r_roll_req <= w_roll_start;
            r_die_err  <= (r_state == S_EVAL) && w_illegal;
            if (w_roll_start) begin
                r_ret_comeout <= (r_state == S_COMEOUT);
                r_lat_cnt     <= LAT_LOAD;
            end else if (r_state == S_WAIT && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - LAT_W'(1);
            end
            if (w_eval_ok) begin
                r_sum <= w_sum;
                if (r_roll_cnt != CNT_MAX) begin
                    r_roll_cnt <= r_roll_cnt + CNT_W'(1);
                end
                if (w_set_point) begin
                    r_point <= w_sum;
                end
            end
            if (w_new_game) begin
                r_sum      <= '0;
                r_point    <= '0;
                r_roll_cnt <= '0;
            end
        end
    end

`ifdef CRAPS_STATS_EN
    logic [CNT_W-1:0] r_wins;
    logic [CNT_W-1:0] r_losses;

    // Entry to WIN/LOSE only ever happens from a legal EVAL, so count there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wins   <= '0;
            r_losses <= '0;
        end else begin
            if (w_eval_ok && w_is_win && r_wins != CNT_MAX) begin
                r_wins <= r_wins + CNT_W'(1);
            end
            if (w_eval_ok && w_is_lose && r_losses != CNT_MAX) begin
                r_losses <= r_losses + CNT_W'(1);
            end
        end
    end

    assign wins   = r_wins;
    assign losses = r_losses;
`else
    assign wins   = '0;
    assign losses = '0;
`endif

    assign roll_req = r_roll_req;
    assign sum      = r_sum;
    assign point    = r_point;
    assign win      = (r_state == S_WIN);
    assign lose     = (r_state == S_LOSE);
    assign die_err  = r_die_err;
    assign roll_cnt = r_roll_cnt;

endmodule
